// File: rtl/step_dir_monitor.sv
// -----------------------------------------------------------------------------
// step_dir_monitor
//
// Receive-side decoder for an A4988-style STEP/DIR pair. Turns accepted STEP
// rises into a signed absolute position, measures the spacing between rises,
// flags pulses that break the driver's timing limits and reports whether the
// motor is currently being stepped.
//
// Ports
//   CLOCK_50      in   system clock, all logic on the rising edge
//   reset_n       in   asynchronous reset, active low
//   step_in       in   STEP pin, asynchronous to CLOCK_50
//   dir_in        in   DIR pin, asynchronous; 1 = CW (+1), 0 = CCW (-1)
//   clear         in   synchronous clear of position, period and sticky errors
//   position      out  signed step position, wraps modulo 2^POS_WIDTH
//   step_strobe   out  one-cycle pulse per accepted STEP rise
//   step_dir      out  direction applied to the most recent step
//   period        out  cycles between the last two accepted rises (saturating)
//   period_valid  out  period holds a real measurement
//   moving        out  a rise was accepted within the last IDLE_TIMEOUT cycles
//   err_pulse     out  one-cycle pulse on any timing violation
//   err_sticky    out  {dir_setup, low_short, high_short}, held until clear
// -----------------------------------------------------------------------------
module step_dir_monitor #(
    parameter int POS_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_HIGH     = 50,
    parameter int MIN_LOW      = 50,
    parameter int DIR_SETUP    = 10,
    parameter int IDLE_TIMEOUT = 5000000
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic                        step_in,
    input  logic                        dir_in,
    input  logic                        clear,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        step_strobe,
    output logic                        step_dir,
    output logic [PERIOD_WIDTH-1:0]     period,
    output logic                        period_valid,
    output logic                        moving,
    output logic                        err_pulse,
    output logic [2:0]                  err_sticky
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // The pulse-width counter only needs to reach the larger of the two limits.
    localparam int MAX_WIDTH = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int WW        = $clog2(MAX_WIDTH + 1) + 1;
    localparam logic [WW-1:0] WIDTH_SAT  = WW'(MAX_WIDTH);
    localparam logic [WW-1:0] WIDTH_ONE  = WW'(1);
    localparam logic [WW-1:0] MIN_HIGH_C = WW'(MIN_HIGH);
    localparam logic [WW-1:0] MIN_LOW_C  = WW'(MIN_LOW);

    localparam int DW = $clog2(DIR_SETUP + 1) + 1;
    localparam logic [DW-1:0] DIR_SAT = DW'(DIR_SETUP);
    localparam logic [DW-1:0] DIR_ONE = DW'(1);

    localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] IDLE_C  = PERIOD_WIDTH'(IDLE_TIMEOUT);

    localparam logic [POS_WIDTH-1:0] POS_PLUS  = POS_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0] POS_MINUS = '1;

    logic                    step_meta;
    logic                    step_s;
    logic                    dir_meta;
    logic                    dir_s;
    logic [1:0]              sync_primed;
    logic [1:0]              state;
    logic [WW-1:0]           width_cnt;
    logic                    dir_last;
    logic [DW-1:0]           dir_cnt;
    logic [DW-1:0]           dir_age;
    logic [PERIOD_WIDTH-1:0] per_cnt;
    logic                    seen_rise;
    logic                    rise_seen;
    logic                    fall_seen;
    logic                    accept;
    logic                    low_short;
    logic                    dir_bad;
    logic                    high_short;

    // Two-flop synchronizers. sync_primed fills with ones two edges after
    // reset, marking the point where step_s reflects the real pin rather than
    // the synchronizer's reset value.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            step_meta   <= 1'b0;
            step_s      <= 1'b0;
            dir_meta    <= 1'b0;
            dir_s       <= 1'b0;
            sync_primed <= 2'b00;
        end else begin
            step_meta   <= step_in;
            step_s      <= step_meta;
            dir_meta    <= dir_in;
            dir_s       <= dir_meta;
            sync_primed <= {sync_primed[0], 1'b1};
        end
    end

    assign rise_seen = (state == ST_LOW) && step_s;
    assign fall_seen = (state == ST_HIGH) && !step_s;
    // A rise coinciding with clear moves the FSM but is otherwise discarded.
    assign accept    = rise_seen && !clear;

    // Age of the current DIR level; a change seen this very cycle counts as zero.
    assign dir_age    = (dir_s != dir_last) ? '0 : dir_cnt;
    assign low_short  = accept && seen_rise && (width_cnt < MIN_LOW_C);
    assign dir_bad    = accept && (dir_age < DIR_SAT);
    assign high_short = fall_seen && (width_cnt < MIN_HIGH_C);

    // Edge-tracking FSM. INIT only leaves once the synchronizer is primed and
    // reports STEP low, so a pin already high at reset release is ignored.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT: if (sync_primed[1] && !step_s) state <= ST_LOW;
                ST_LOW:  if (step_s) state <= ST_HIGH;
                ST_HIGH: if (!step_s) state <= ST_LOW;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Width of the current STEP level. It restarts at one on every level
    // change so that, on the cycle the next edge is seen, it equals the
    // number of cycles the previous level lasted.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            width_cnt <= '0;
        end else if (rise_seen || fall_seen || (state == ST_INIT)) begin
            width_cnt <= WIDTH_ONE;
        end else if (width_cnt != WIDTH_SAT) begin
            width_cnt <= width_cnt + WIDTH_ONE;
        end
    end

    // Saturating age of the DIR level, used for the setup check at each rise.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            dir_last <= 1'b0;
            dir_cnt  <= '0;
        end else begin
            dir_last <= dir_s;
            if (dir_age != DIR_SAT) begin
                dir_cnt <= dir_age + DIR_ONE;
            end else begin
                dir_cnt <= dir_age;
            end
        end
    end

    // Cycles elapsed since the last accepted rise (the rise cycle itself being
    // zero), saturating. It also times out the moving flag.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
            moving  <= 1'b0;
        end else begin
            if (accept) begin
                per_cnt <= PER_ONE;
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + PER_ONE;
            end
            if (accept) begin
                moving <= 1'b1;
            end else if (per_cnt >= IDLE_C) begin
                moving <= 1'b0;
            end
        end
    end

    // Position, period capture and error reporting. seen_rise doubles as the
    // first-rise exemption for the low-width check and as the gate for
    // period_valid, so clear re-arms both at once.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            position     <= '0;
            step_strobe  <= 1'b0;
            step_dir     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;
            err_sticky   <= 3'b000;
            seen_rise    <= 1'b0;
        end else begin
            step_strobe <= accept;
            err_pulse   <= low_short || dir_bad || high_short;
            if (clear) begin
                position     <= '0;
                period       <= '0;
                period_valid <= 1'b0;
                err_sticky   <= 3'b000;
                seen_rise    <= 1'b0;
            end else begin
                if (accept) begin
                    position  <= position + (dir_s ? POS_PLUS : POS_MINUS);
                    step_dir  <= dir_s;
                    period    <= per_cnt;
                    seen_rise <= 1'b1;
                    if (seen_rise) begin
                        period_valid <= 1'b1;
                    end
                end
                err_sticky <= err_sticky | {dir_bad, low_short, high_short};
            end
        end
    end

endmodule

// File: tb/tb_step_dir_monitor.sv
// -----------------------------------------------------------------------------
// tb_step_dir_monitor
//
// Self-checking bench for step_dir_monitor, run with shrunken parameters so
// that wrap-around, saturation and idle timeout fit in a short run. Pulses are
// described by pin-level widths in clock cycles; the reference model derives
// every expected value from those widths and the event times.
// -----------------------------------------------------------------------------
module tb_step_dir_monitor;

    localparam int POS_W    = 8;
    localparam int PER_W    = 10;
    localparam int MIN_HIGH = 8;
    localparam int MIN_LOW  = 8;
    localparam int DIR_SET  = 4;
    localparam int IDLE     = 600;
    localparam int PER_SAT  = (1 << PER_W) - 1;
    localparam int TAIL     = 4;

    logic             CLOCK_50 = 1'b0;
    logic             reset_n  = 1'b0;
    logic             step_in  = 1'b1;
    logic             dir_in   = 1'b1;
    logic             clear    = 1'b0;
    logic [POS_W-1:0] position;
    logic             step_strobe;
    logic             step_dir;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             moving;
    logic             err_pulse;
    logic [2:0]       err_sticky;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       now = 0;
    int       m_pos = 0;
    int       m_strobes = 0;
    int       m_errs = 0;
    int       m_period = 0;
    int       last_rise = 0;
    int       last_rise_drive = 0;
    int       last_fall = 0;
    int       last_dir = -1000;
    bit       m_seen = 1'b0;
    bit       m_valid = 1'b0;
    bit       m_dir = 1'b0;
    bit [2:0] m_sticky = 3'b000;

    int strobe_seen = 0;
    int err_seen = 0;

    typedef struct {
        int         lo;
        bit         dir;
        int         lead;
        int         hi;
        logic [7:0] pos;
        bit         sdir;
        logic [2:0] sticky;
        int         errs;
        bit         valid;
        int         per;
    } vec_t;

    vec_t vecs[7];

    step_dir_monitor #(
        .POS_WIDTH   (POS_W),
        .PERIOD_WIDTH(PER_W),
        .MIN_HIGH    (MIN_HIGH),
        .MIN_LOW     (MIN_LOW),
        .DIR_SETUP   (DIR_SET),
        .IDLE_TIMEOUT(IDLE)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .step_in     (step_in),
        .dir_in      (dir_in),
        .clear       (clear),
        .position    (position),
        .step_strobe (step_strobe),
        .step_dir    (step_dir),
        .period      (period),
        .period_valid(period_valid),
        .moving      (moving),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Pulse outputs are tallied on the falling edge, away from the active edge.
    always @(negedge CLOCK_50) begin
        if (step_strobe) strobe_seen++;
        if (err_pulse) err_seen++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        now++;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural rules applied at the moment a rise is driven on the pin.
    task automatic modelRise();
        int  low_w;
        int  age;
        bit  rise_err;
        low_w = now - last_fall;
        age = now - last_dir;
        rise_err = 1'b0;
        if (m_seen && low_w < MIN_LOW) begin
            m_sticky[1] = 1'b1;
            rise_err = 1'b1;
        end
        if (age < DIR_SET) begin
            m_sticky[2] = 1'b1;
            rise_err = 1'b1;
        end
        if (rise_err) m_errs++;
        m_pos = m_pos + (dir_in ? 1 : -1);
        m_dir = dir_in;
        if (m_seen) begin
            m_valid = 1'b1;
            m_period = (now - last_rise > PER_SAT) ? PER_SAT : now - last_rise;
        end
        m_seen = 1'b1;
        last_rise = now;
        last_rise_drive = now;
        m_strobes++;
    endtask

    task automatic modelFall();
        if (now - last_rise_drive < MIN_HIGH) begin
            m_sticky[0] = 1'b1;
            m_errs++;
        end
        last_fall = now;
    endtask

    task automatic modelClear();
        m_pos = 0;
        m_sticky = 3'b000;
        m_valid = 1'b0;
        m_seen = 1'b0;
        m_period = 0;
    endtask

    task automatic clearPulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        modelClear();
        tick();
    endtask

    // One STEP pulse: lo cycles low (DIR switched to nd lead cycles before the
    // rise when it differs), hi cycles high, then a short low tail so the fall
    // has been seen before anything is checked.
    task automatic applyStimulus(input int lo, input bit nd, input int lead, input int hi);
        for (int t = 0; t < lo; t++) begin
            if (nd != dir_in && t == lo - lead) begin
                dir_in = nd;
                last_dir = now;
            end
            tick();
        end
        step_in = 1'b1;
        modelRise();
        repeat (hi) tick();
        step_in = 1'b0;
        modelFall();
        repeat (TAIL) tick();
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".position"}, int'(position), m_pos & 255);
        checkOutput({tag, ".step_dir"}, int'(step_dir), int'(m_dir));
        checkOutput({tag, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
        checkOutput({tag, ".period_valid"}, int'(period_valid), int'(m_valid));
        checkOutput({tag, ".strobes"}, strobe_seen, m_strobes);
        checkOutput({tag, ".err_pulses"}, err_seen, m_errs);
        if (m_valid) checkOutput({tag, ".period"}, int'(period), m_period);
    endtask

    initial begin
        int strobes_before;
        int errs_before;
        int lo;
        int hi;
        int lead;
        bit nd;

        //               lo  dir lead hi   pos     sdir  sticky  errs valid per
        vecs[0] = '{6,  1'b0, 0, 10, 8'hFF, 1'b0, 3'b000, 0, 1'b0, 0};
        vecs[1] = '{4,  1'b0, 0,  8, 8'hFE, 1'b0, 3'b000, 0, 1'b1, 18};
        vecs[2] = '{3,  1'b0, 0,  8, 8'hFD, 1'b0, 3'b010, 1, 1'b1, 15};
        vecs[3] = '{6,  1'b1, 4,  8, 8'hFE, 1'b1, 3'b010, 0, 1'b1, 18};
        vecs[4] = '{6,  1'b0, 3,  8, 8'hFD, 1'b0, 3'b110, 1, 1'b1, 18};
        vecs[5] = '{6,  1'b0, 0,  7, 8'hFC, 1'b0, 3'b111, 1, 1'b1, 18};
        vecs[6] = '{2,  1'b1, 2,  4, 8'hFD, 1'b1, 3'b111, 2, 1'b1, 13};

        // Reset with STEP held high: everything reads zero.
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("reset.position", int'(position), 0);
        checkOutput("reset.step_strobe", int'(step_strobe), 0);
        checkOutput("reset.step_dir", int'(step_dir), 0);
        checkOutput("reset.period", int'(period), 0);
        checkOutput("reset.period_valid", int'(period_valid), 0);
        checkOutput("reset.moving", int'(moving), 0);
        checkOutput("reset.err_pulse", int'(err_pulse), 0);
        checkOutput("reset.err_sticky", int'(err_sticky), 0);

        // Release with STEP still high; the held level must not count.
        reset_n = 1'b1;
        now = 0;
        last_dir = -1000;
        repeat (200) tick();
        step_in = 1'b0;
        last_fall = now;
        repeat (20) tick();
        checkOutput("held_high.strobes", strobe_seen, 0);
        checkOutput("held_high.position", int'(position), 0);
        checkOutput("held_high.err_sticky", int'(err_sticky), 0);

        // CW run then CCW run.
        repeat (10) applyStimulus(6, 1'b1, 0, 10);
        checkOutput("cw.position", int'(position), 10);
        checkOutput("cw.period", int'(period), 20);
        checkOutput("cw.period_valid", int'(period_valid), 1);
        checkOutput("cw.err_sticky", int'(err_sticky), 0);
        checkOutput("cw.moving", int'(moving), 1);
        applyStimulus(8, 1'b0, 6, 10);
        repeat (14) applyStimulus(6, 1'b0, 0, 10);
        checkOutput("ccw.position", int'(position), 8'hFB);
        checkOutput("ccw.step_dir", int'(step_dir), 0);
        checkModel("ccw");

        // Table of boundary pulses starting from a clear.
        clearPulse();
        checkOutput("clear.position", int'(position), 0);
        checkOutput("clear.period", int'(period), 0);
        checkOutput("clear.period_valid", int'(period_valid), 0);
        for (int i = 0; i < 7; i++) begin
            errs_before = err_seen;
            strobes_before = strobe_seen;
            applyStimulus(vecs[i].lo, vecs[i].dir, vecs[i].lead, vecs[i].hi);
            checkOutput($sformatf("vec%0d.position", i), int'(position), int'(vecs[i].pos));
            checkOutput($sformatf("vec%0d.step_dir", i), int'(step_dir), int'(vecs[i].sdir));
            checkOutput($sformatf("vec%0d.err_sticky", i), int'(err_sticky), int'(vecs[i].sticky));
            checkOutput($sformatf("vec%0d.err_pulses", i), err_seen - errs_before, vecs[i].errs);
            checkOutput($sformatf("vec%0d.strobes", i), strobe_seen - strobes_before, 1);
            checkOutput($sformatf("vec%0d.period_valid", i), int'(period_valid), int'(vecs[i].valid));
            if (vecs[i].valid) checkOutput($sformatf("vec%0d.period", i), int'(period), vecs[i].per);
        end

        // Randomised pulses against the model.
        for (int i = 0; i < 40; i++) begin
            lo = $urandom_range(1, 10);
            hi = $urandom_range(3, 14);
            lead = $urandom_range(1, lo);
            nd = ($urandom_range(0, 2) == 0) ? ~dir_in : dir_in;
            applyStimulus(lo, nd, lead, hi);
            checkModel($sformatf("rand%0d", i));
        end

        // Position wrap 0x7F -> 0x80 and strobe latency.
        clearPulse();
        if (dir_in == 1'b0) begin
            dir_in = 1'b1;
            last_dir = now;
        end
        repeat (10) tick();
        repeat (127) applyStimulus(4, 1'b1, 0, 8);
        checkOutput("wrap.before", int'(position), 8'h7F);
        repeat (4) tick();
        step_in = 1'b1;
        modelRise();
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge CLOCK_50);
            checkOutput($sformatf("latency.edge%0d", k), int'(step_strobe), int'(k == 3));
        end
        repeat (4) tick();
        step_in = 1'b0;
        modelFall();
        repeat (TAIL) tick();
        checkOutput("wrap.after", int'(position), 8'h80);
        checkModel("wrap");

        // A rise in the same cycle as clear is discarded.
        repeat (10) tick();
        strobes_before = strobe_seen;
        step_in = 1'b1;
        last_rise_drive = now;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        modelClear();
        repeat (7) tick();
        step_in = 1'b0;
        modelFall();
        repeat (TAIL) tick();
        checkOutput("clear_rise.strobes", strobe_seen - strobes_before, 0);
        checkOutput("clear_rise.position", int'(position), 0);
        checkOutput("clear_rise.period_valid", int'(period_valid), 0);

        // Next rise is accepted as the first after clear, then idle timeout.
        applyStimulus(10, 1'b1, 0, 10);
        checkOutput("after_clear.position", int'(position), 1);
        repeat (500 - 10 - TAIL) tick();
        checkOutput("idle.moving_early", int'(moving), 1);
        repeat (120) tick();
        checkOutput("idle.moving_late", int'(moving), 0);

        // A gap beyond the counter range reads as all-ones.
        applyStimulus(480, 1'b1, 0, 10);
        checkOutput("saturate.period", int'(period), PER_SAT);
        checkOutput("saturate.period_valid", int'(period_valid), 1);
        checkOutput("saturate.moving", int'(moving), 1);
        checkModel("saturate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
